// File: rtl/bconv_kxk.sv
// Binary-weight KxK convolution engine: serial weight load, valid-qualified
// column beats, free-running pipelined adder tree with saturated output.
module bconv_kxk #(
    parameter int K    = 5,
    parameter int DW   = 32,
    parameter int OW   = 32,
    parameter int MAXN = 28
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              keep_wt,
    input  logic [7:0]        cfg_n,
    input  logic              wt_valid,
    input  logic              wt_bit,
    input  logic              taps_valid,
    input  logic [K*DW-1:0]   taps,
    output logic [OW-1:0]     dout,
    output logic              ovalid,
    output logic              done,
    output logic              busy,
    output logic              cfg_err
);
    localparam int NL = K * K;
    localparam int LG = $clog2(NL);
    localparam int SW = DW + 1 + LG;
    localparam int XW = (SW > OW) ? SW : OW;

    localparam logic [7:0]           K8      = 8'(K);
    localparam logic [7:0]           MAXN8   = 8'(MAXN);
    localparam logic [LG-1:0]        WLAST   = LG'(NL - 1);
    localparam logic signed [XW-1:0] SAT_MAX = {{(XW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [XW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

    state_t                state;
    state_t                state_nx;
    logic [7:0]            n_reg;
    logic [7:0]            col;
    logic [7:0]            row;
    logic [LG-1:0]         widx;
    logic [NL-1:0]         wt;
    logic [K*DW-1:0]       win [K];
    logic [LG:0]           vtag;
    logic [LG:0]           ltag;
    logic signed [SW-1:0]  prod [2*NL];
    logic signed [SW-1:0]  lvl  [1:LG][2*NL];
    logic signed [XW-1:0]  sum_x;
    logic signed [OW-1:0]  sat;

    logic cfg_bad;
    logic accept;
    logic producing;
    logic last_beat;
    logic load_last;

    assign cfg_bad   = (cfg_n < K8) || (cfg_n > MAXN8);
    assign accept    = (state == RUN) && taps_valid;
    assign producing = (col >= K8 - 8'd1);
    assign last_beat = accept && (row == n_reg - K8) && (col == n_reg - 8'd1);
    assign load_last = (state == LOAD) && wt_valid && (widx == WLAST);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start && !cfg_bad) state_nx = keep_wt ? RUN : LOAD;
            LOAD:    if (load_last) state_nx = RUN;
            RUN:     if (last_beat) state_nx = DRAIN;
            DRAIN:   if (done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Run configuration, weight store and window position counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            n_reg   <= '0;
            col     <= '0;
            row     <= '0;
            widx    <= '0;
            wt      <= '0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= (state == IDLE) && start && cfg_bad;
            if ((state == IDLE) && start && !cfg_bad) begin
                n_reg <= cfg_n;
                col   <= '0;
                row   <= '0;
                widx  <= '0;
            end
            if ((state == LOAD) && wt_valid) begin
                wt[widx] <= wt_bit;
                widx     <= widx + LG'(1);
            end
            if (accept) begin
                if (col == n_reg - 8'd1) begin
                    col <= '0;
                    row <= row + 8'd1;
                end else begin
                    col <= col + 8'd1;
                end
            end
        end
    end

    // Entries past NL stay zero so odd operands pass through the tree unchanged.
    always_comb begin
        for (int i = 0; i < 2*NL; i++) prod[i] = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                prod[r*K+c] = wt[r*K+c] ?  SW'($signed(win[c][(K-1-r)*DW +: DW]))
                                        : -SW'($signed(win[c][(K-1-r)*DW +: DW]));
            end
        end
    end

    always_comb begin
        sum_x = XW'(lvl[LG][0]);
        if (sum_x > SAT_MAX)      sat = OW'(SAT_MAX);
        else if (sum_x < SAT_MIN) sat = OW'(SAT_MIN);
        else                      sat = OW'(sum_x);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int j = 0; j < K; j++) win[j] <= '0;
            for (int l = 1; l <= LG; l++)
                for (int i = 0; i < 2*NL; i++) lvl[l][i] <= '0;
            vtag   <= '0;
            ltag   <= '0;
            dout   <= '0;
            ovalid <= 1'b0;
            done   <= 1'b0;
        end else begin
            if (accept) begin
                for (int j = 0; j < K-1; j++) win[j] <= win[j+1];
                win[K-1] <= taps;
            end
            vtag <= {vtag[LG-1:0], accept && producing};
            ltag <= {ltag[LG-1:0], last_beat};
            for (int i = 0; i < NL; i++) lvl[1][i] <= prod[2*i] + prod[2*i+1];
            for (int l = 2; l <= LG; l++)
                for (int i = 0; i < NL; i++) lvl[l][i] <= lvl[l-1][2*i] + lvl[l-1][2*i+1];
            ovalid <= vtag[LG];
            done   <= ltag[LG];
            if (vtag[LG]) dout <= sat;
        end
    end
endmodule

// File: doc/bconv_kxk.md
# bconv_kxk

Parametrised binary-weight K×K convolution engine: the next-generation replacement for the fixed 5×5, count-timed convolver in the BNN datapath. It loads K·K one-bit weights serially, takes one K-pixel column per beat from the line-buffer/sliding-window block, and computes ±1-weighted sums through a pipelined adder tree. Output is saturated to OW bits. Unlike its predecessor, every beat is qualified by a valid strobe, so gaps in the input stream are tolerated. Row width is a run-time input, and weights can be retained across runs.

## Interface
- K, 5, kernel size (odd, 3..7)
- DW, 32, signed pixel width
- OW, 32, signed output width (saturated)
- MAXN, 28, largest legal row width
- clk  in  1  clock, rising edge
- rstn  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  one-cycle run request, honoured only in IDLE
- keep_wt  in  1  sampled with start: 1 = reuse stored weights and skip LOAD
- cfg_n  in  8  row/column size N of the square input map, sampled with start
- wt_valid  in  1  weight bit strobe (LOAD only)
- wt_bit  in  1  weight: 1 → +x, 0 → −x; row-major, index 0 = top-left
- taps_valid  in  1  column beat strobe (RUN only)
- taps  in  K·DW  column, row 0 in MSBs, signed
- dout  out  OW  convolution result
- ovalid  out  1  dout valid
- done  out  1  one-cycle pulse coincident with the last ovalid
- busy  out  1  high in every state except IDLE
- cfg_err  out  1  one-cycle pulse when start is rejected

## Operation
- FSM states: IDLE, LOAD, RUN, DRAIN.
- **IDLE + start**
  - If cfg_n < K or cfg_n > MAXN: pulse cfg_err and stay in IDLE.
  - Otherwise latch N = cfg_n. Go to RUN if keep_wt = 1, else to LOAD with the weight index cleared.
- **LOAD**
  - Each wt_valid stores wt_bit at the current index and increments it.
  - After index K·K−1 is stored, go to RUN.
  - Previously stored weights are overwritten bit by bit. Weights are never cleared except by reset.
- **RUN**
  - Each taps_valid beat shifts the column into a K-column window register. Column K−1 is the newest.
  - Counters: col (0..N−1) and row (0..N−K) advance on accepted beats.
  - The beat is tagged "producing" when col ≥ K−1.
  - When the beat with row = N−K and col = N−1 is accepted, go to DRAIN.
  - Total beats per run: N·(N−K+1). Total outputs per run: (N−K+1)².
- **DRAIN**: wait until the last producing beat reaches the output, then assert done and return to IDLE.
- **Arithmetic**
  - Product p = k ? x : −x, computed at full width DW+1.
  - Adder tree: binary, ceil(log2(K·K)) registered levels, with odd operands passed through.
  - Internal sum width is DW+1+ceil(log2(K·K)).
  - Final stage saturates to the signed OW range [−2^(OW−1), 2^(OW−1)−1].
- The window is not cleared at row start. The first K−1 beats of each row are non-producing, so stale data never reaches a valid output.
- **Ignored inputs**
  - taps_valid outside RUN.
  - wt_valid outside LOAD.
  - start while busy.

## Timing
- Reset values:
  - dout = 0, ovalid = 0, done = 0, busy = 0, cfg_err = 0.
  - All weights = 0, FSM in IDLE, all counters = 0.
- start at cycle t → busy = 1 from t+1.
- Weight bits are accepted from the LOAD state, one per wt_valid cycle. Back-to-back is allowed.
- The first taps beat is accepted in the cycle after entry to RUN.
- Latency: producing beat accepted at cycle t → ovalid at cycle t + LAT, with LAT = 2 + ceil(log2(K·K)). For K = 5, LAT = 7.
  - The pipeline free-runs; only the valid tag travels with the data.
  - Gaps in taps_valid give matching gaps in ovalid.
- dout holds its last value while ovalid = 0.
- done is coincident with the final ovalid. busy drops the following cycle.
- start is accepted in the cycle after done at the earliest.
- Reset mid-operation: all state returns to reset values immediately. In-flight results are discarded and no done is issued.

## Test plan
- **All ones, K = 5, N = 12.** Weights all 1, taps all +1 with taps_valid continuous.
  - Expect 64 outputs, each dout = 25.
  - First ovalid 7 cycles after the 5th beat; done with the 64th output.
- **Sign mix.** Weight index 12 = 0, rest = 1; pixel value = 2.
  - Expect every dout = 2·24 − 2 = 46, over 576 outputs for N = 28.
- **Saturation.** OW = DW = 32, weights all 1, pixels 0x7FFFFFFF → dout = 0x7FFFFFFF.
  - With weights all 0, the same pixels → dout = 0x80000000.
- **Stalls plus weight reuse.**
  - Run 1: taps_valid toggles every other cycle. ovalid spacing mirrors the input spacing and values match the continuous-stream run.
  - Run 2: start with keep_wt = 1 enters RUN directly and gives identical results.
- **Config error.** start with cfg_n = 4 (below K) or cfg_n = 29 (above MAXN) → cfg_err pulses for one cycle; busy stays 0 and FSM stays in IDLE.
- **Mid-run reset.** Deassert rstn mid-RUN, after 30 beats.
  - All outputs return to 0 and no done is issued.
  - The next run must reload weights (weights reset to 0).
